// File: rtl/control_pkg.sv
// Shared encodings for the MIPS single-cycle control unit.
// Holds the opcode and funct field values, the aluop encoding passed from the
// main decoder to the ALU decoder, the ALU operation codes, and the bundled
// control-word type carried through the optional output register.
package control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic       regwrite;
      logic       regdst;
      logic       alusrc;
      logic       branch;
      logic       memwrite;
      logic       memtoreg;
      logic       jump;
      logic [2:0] alucontrol;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: aluop + funct -> 3-bit ALU operation code.
// Ports:
//   aluop         : from main decoder (11 treated like 10)
//   funct         : instr[5:0]
//   alucontrol    : ALU operation code
//   funct_illegal : funct-decoded op with unsupported funct (alucontrol = add)
module alu_decoder
   import control_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol,
   output logic       funct_illegal
);

   always_comb begin
      alucontrol    = ALU_ADD;
      funct_illegal = 1'b0;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         default: begin
            case (funct)
               F_ADD:   alucontrol = ALU_ADD;
               F_SUB:   alucontrol = ALU_SUB;
               F_AND:   alucontrol = ALU_AND;
               F_OR:    alucontrol = ALU_OR;
               F_SLT:   alucontrol = ALU_SLT;
               default: funct_illegal = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/main_decoder.sv
// Main decoder: opcode -> datapath strobes, aluop and opcode-illegal flag.
// Ports:
//   op       : instr[31:26]
//   regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump : strobes
//   aluop    : selects ALU decoder behaviour
//   op_illegal : opcode not supported (all strobes forced 0)
module main_decoder
   import control_pkg::*;
(
   input  logic [5:0] op,
   output logic       regwrite,
   output logic       regdst,
   output logic       alusrc,
   output logic       branch,
   output logic       memwrite,
   output logic       memtoreg,
   output logic       jump,
   output aluop_t     aluop,
   output logic       op_illegal
);

   always_comb begin
      regwrite   = 1'b0;
      regdst     = 1'b0;
      alusrc     = 1'b0;
      branch     = 1'b0;
      memwrite   = 1'b0;
      memtoreg   = 1'b0;
      jump       = 1'b0;
      aluop      = ALUOP_ADD;
      op_illegal = 1'b0;
      case (op)
         OP_RTYPE: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            aluop    = ALUOP_FUNCT;
         end
         OP_LW: begin
            regwrite = 1'b1;
            alusrc   = 1'b1;
            memtoreg = 1'b1;
         end
         OP_SW: begin
            alusrc   = 1'b1;
            memwrite = 1'b1;
         end
         OP_BEQ: begin
            branch = 1'b1;
            aluop  = ALUOP_SUB;
         end
         OP_ADDI: begin
            regwrite = 1'b1;
            alusrc   = 1'b1;
         end
         OP_J: begin
            jump = 1'b1;
         end
         default: op_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Control unit for the single-cycle MIPS datapath.
// Two-level decode (main_decoder, alu_decoder) with an optional output register.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//                (both unused when REGISTER_OUTPUTS = 0)
//   instr      : instruction word; only opcode and funct are looked at
//   memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump : strobes
//   alucontrol : ALU operation code
//   illegal    : unsupported opcode, or unsupported funct for R-type
module control_unit
   import control_pkg::*;
#(
   parameter bit REGISTER_OUTPUTS = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   output logic        memtoreg,
   output logic        memwrite,
   output logic        branch,
   output logic        alusrc,
   output logic        regdst,
   output logic        regwrite,
   output logic        jump,
   output logic [2:0]  alucontrol,
   output logic        illegal
);

   logic   md_regwrite;
   logic   op_illegal;
   logic   funct_illegal;
   aluop_t aluop;
   ctrl_t  ctrl_d;
   ctrl_t  ctrl_q;
   logic   unused_fields;

   assign unused_fields = ^instr[25:6];

   main_decoder u_main_decoder (
      .op         (instr[31:26]),
      .regwrite   (md_regwrite),
      .regdst     (ctrl_d.regdst),
      .alusrc     (ctrl_d.alusrc),
      .branch     (ctrl_d.branch),
      .memwrite   (ctrl_d.memwrite),
      .memtoreg   (ctrl_d.memtoreg),
      .jump       (ctrl_d.jump),
      .aluop      (aluop),
      .op_illegal (op_illegal)
   );

   alu_decoder u_alu_decoder (
      .aluop         (aluop),
      .funct         (instr[5:0]),
      .alucontrol    (ctrl_d.alucontrol),
      .funct_illegal (funct_illegal)
   );

   // An unknown R-type funct must not write the register file.
   assign ctrl_d.regwrite = md_regwrite & ~funct_illegal;
   assign ctrl_d.illegal  = op_illegal | funct_illegal;

   generate
      if (REGISTER_OUTPUTS) begin : g_reg
         always_ff @(posedge clk) begin
            if (reset) ctrl_q <= '0;
            else       ctrl_q <= ctrl_d;
         end
      end else begin : g_comb
         logic unused_clk_reset;
         assign unused_clk_reset = clk ^ reset;
         assign ctrl_q = ctrl_d;
      end
   endgenerate

   assign regwrite   = ctrl_q.regwrite;
   assign regdst     = ctrl_q.regdst;
   assign alusrc     = ctrl_q.alusrc;
   assign branch     = ctrl_q.branch;
   assign memwrite   = ctrl_q.memwrite;
   assign memtoreg   = ctrl_q.memtoreg;
   assign jump       = ctrl_q.jump;
   assign alucontrol = ctrl_q.alucontrol;
   assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a registered instance and a
// combinational instance share the same stimulus and are compared against a
// flat truth-table model of the instruction set.
module tb_control_unit;

   logic        clk;
   logic        reset;
   logic [31:0] instr;

   logic        r_memtoreg, r_memwrite, r_branch, r_alusrc, r_regdst, r_regwrite, r_jump, r_illegal;
   logic [2:0]  r_alucontrol;
   logic        c_memtoreg, c_memwrite, c_branch, c_alusrc, c_regdst, c_regwrite, c_jump, c_illegal;
   logic [2:0]  c_alucontrol;

   int checks = 0;
   int errors = 0;

   control_unit #(.REGISTER_OUTPUTS(1'b1)) dut_reg (
      .clk(clk), .reset(reset), .instr(instr),
      .memtoreg(r_memtoreg), .memwrite(r_memwrite), .branch(r_branch),
      .alusrc(r_alusrc), .regdst(r_regdst), .regwrite(r_regwrite),
      .jump(r_jump), .alucontrol(r_alucontrol), .illegal(r_illegal)
   );

   control_unit #(.REGISTER_OUTPUTS(1'b0)) dut_comb (
      .clk(clk), .reset(reset), .instr(instr),
      .memtoreg(c_memtoreg), .memwrite(c_memwrite), .branch(c_branch),
      .alusrc(c_alusrc), .regdst(c_regdst), .regwrite(c_regwrite),
      .jump(c_jump), .alucontrol(c_alucontrol), .illegal(c_illegal)
   );

   // Bundle order: regwrite regdst alusrc branch memwrite memtoreg jump alucontrol[2:0] illegal
   logic [10:0] got_r, got_c;
   assign got_r = {r_regwrite, r_regdst, r_alusrc, r_branch, r_memwrite, r_memtoreg,
                   r_jump, r_alucontrol, r_illegal};
   assign got_c = {c_regwrite, c_regdst, c_alusrc, c_branch, c_memwrite, c_memtoreg,
                   c_jump, c_alucontrol, c_illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flat reference: one row per instruction, directly from the ISA table.
   function automatic logic [10:0] model(input logic [31:0] i);
      logic [5:0] op;
      logic [5:0] fn;
      op = i[31:26];
      fn = i[5:0];
      case (op)
         6'h00: case (fn)
            6'h20:   return 11'b1100000_010_0;
            6'h22:   return 11'b1100000_110_0;
            6'h24:   return 11'b1100000_000_0;
            6'h25:   return 11'b1100000_001_0;
            6'h2A:   return 11'b1100000_111_0;
            default: return 11'b0100000_010_1;
         endcase
         6'h23:   return 11'b1010010_010_0;
         6'h2B:   return 11'b0010100_010_0;
         6'h04:   return 11'b0001000_110_0;
         6'h08:   return 11'b1010000_010_0;
         6'h02:   return 11'b0000001_010_0;
         default: return 11'b0000000_010_1;
      endcase
   endfunction

   // Applies one instruction at the falling edge, checks the combinational
   // instance immediately and the registered one just after the next rise.
   task automatic apply(input logic [31:0] i, input string name);
      logic [10:0] exp;
      @(negedge clk);
      instr = i;
      exp = model(i);
      #1;
      checks++;
      if (got_c !== exp) begin
         errors++;
         $display("FAIL comb_%s instr=%08h got=%b exp=%b", name, i, got_c, exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (got_r !== exp) begin
         errors++;
         $display("FAIL reg_%s instr=%08h got=%b exp=%b", name, i, got_r, exp);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      instr = 32'h00000020;
      @(posedge clk);
      #1;
      checks++;
      if (got_r !== 11'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=%b", got_r, 11'b0);
      end
      checks++;
      if (got_c !== model(instr)) begin
         errors++;
         $display("FAIL reset_comb_unaffected got=%b exp=%b", got_c, model(instr));
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (got_r !== model(32'h00000020)) begin
         errors++;
         $display("FAIL reset_release got=%b exp=%b", got_r, model(32'h00000020));
      end
   endtask

   task automatic test_directed();
      apply(32'h00000022, "rtype_sub");
      apply(32'h8C000000, "lw");
      apply(32'hAC000000, "sw");
      apply(32'h10000000, "beq");
      apply(32'h08000000, "j");
      apply(32'h00000020, "rtype_add");
      apply(32'h00000024, "rtype_and");
      apply(32'h00000025, "rtype_or");
      apply(32'h0000002A, "rtype_slt");
      apply(32'h20000005, "addi");
      apply(32'hFC000000, "illegal_op");
      apply(32'h00000003, "illegal_funct");
   endtask

   task automatic test_latency();
      logic [10:0] exp_a, exp_b;
      apply(32'h8C000000, "lat_a");
      exp_a = model(32'h8C000000);
      exp_b = model(32'h00000025);
      @(negedge clk);
      instr = 32'h00000025;
      #1;
      checks++;
      if (got_r !== exp_a) begin
         errors++;
         $display("FAIL latency_hold got=%b exp=%b", got_r, exp_a);
      end
      checks++;
      if (got_c !== exp_b) begin
         errors++;
         $display("FAIL latency_comb got=%b exp=%b", got_c, exp_b);
      end
      @(posedge clk);
      #1;
      checks++;
      if (got_r !== exp_b) begin
         errors++;
         $display("FAIL latency_update got=%b exp=%b", got_r, exp_b);
      end
   endtask

   task automatic test_reset_midstream();
      apply(32'h0000002A, "mid_pre");
      @(negedge clk);
      instr = 32'h00000022;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (got_r !== 11'b0) begin
         errors++;
         $display("FAIL mid_reset got=%b exp=%b", got_r, 11'b0);
      end
      checks++;
      if (got_c !== model(32'h00000022)) begin
         errors++;
         $display("FAIL mid_reset_comb got=%b exp=%b", got_c, model(32'h00000022));
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (got_r !== model(32'h00000022)) begin
         errors++;
         $display("FAIL mid_release got=%b exp=%b", got_r, model(32'h00000022));
      end
   endtask

   task automatic test_random();
      logic [5:0] ops [7];
      logic [5:0] fns [6];
      logic [31:0] i;
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h00};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
      for (int n = 0; n < 300; n++) begin
         i = $urandom;
         if ($urandom_range(0, 3) != 0) i[31:26] = ops[$urandom_range(0, 6)];
         if ($urandom_range(0, 3) != 0) i[5:0] = fns[$urandom_range(0, 4)];
         apply(i, "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] seq [5];
      seq = '{32'h00000003, 32'hFC000000, 32'h20000005, 32'h10000000, 32'h0000002A};
      for (int n = 0; n < 5; n++) apply(seq[n], "b2b");
   endtask

   initial begin
      reset = 1'b1;
      instr = 32'h0;
      test_reset();
      test_directed();
      test_latency();
      test_reset_midstream();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
